// File: rtl/hd44780_sink_if.sv
// Strobe/bus bundle between an HD44780-style LCD controller (master) and the sink model (slave).
interface hd44780_sink_if;
    logic       e;
    logic       rs;
    logic [3:0] db;
    logic       busy;
    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_data;
    logic       violation;

    modport master (
        output e, rs, db,
        input  busy, byte_valid, byte_rs, byte_data, violation
    );

    modport slave (
        input  e, rs, db,
        output busy, byte_valid, byte_rs, byte_data, violation
    );
endinterface

// File: rtl/hd44780_sink.sv
// HD44780 LCD sink: decodes strobed nibbles/bytes, models busy timing, DDRAM and address counter.
// Optional CGRAM storage and read port are enabled with `define HD44780_SINK_CGRAM_EN.
module hd44780_sink #(
    parameter int CMD_BUSY_CYCLES   = 20,
    parameter int CLEAR_BUSY_CYCLES = 410
) (
    input  logic       clk,
    input  logic       rst,
    hd44780_sink_if.slave bus,
    input  logic [6:0] raddr,
    output logic [7:0] rdata,
    output logic [6:0] ac,
    output logic       four_bit,
    output logic       two_line,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink,
    output logic       entry_id,
    output logic       entry_s
`ifdef HD44780_SINK_CGRAM_EN
    ,
    input  logic [5:0] cg_raddr,
    output logic [7:0] cg_rdata
`endif
);

    localparam int CLR_CYCLES = (CLEAR_BUSY_CYCLES > 128) ? CLEAR_BUSY_CYCLES : 128;

    logic       e_r;
    logic       phase_lo_r;
    logic [3:0] hi_r;
    logic       busy_r;
    logic [15:0] busy_cnt_r;
    logic       byte_valid_r;
    logic       byte_rs_r;
    logic [7:0] byte_data_r;
    logic       violation_r;
    logic [6:0] ac_r;
    logic       cg_sel_r;
    logic [5:0] cg_addr_r;
    logic       four_bit_r;
    logic       two_line_r;
    logic       disp_on_r;
    logic       cursor_on_r;
    logic       blink_r;
    logic       entry_id_r;
    logic       entry_s_r;
    logic       clr_active_r;
    logic [6:0] clr_addr_r;
    logic [7:0] rdata_r;
    logic [7:0] ddram [0:127];

    logic       strobe_s;
    logic       accept_s;
    logic [7:0] full_byte_s;
    logic [15:0] busy_load_s;
    logic       ddram_we_s;
    logic [6:0] ddram_waddr_s;
    logic [7:0] ddram_wdata_s;

    // Unmapped addresses fall through to plain +/-1 mod 128.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc, input logic two);
        logic [6:0] r;
        if (two) begin
            if (inc) begin
                if (a == 7'h27)      r = 7'h40;
                else if (a == 7'h67) r = 7'h00;
                else                 r = a + 7'd1;
            end else begin
                if (a == 7'h00)      r = 7'h67;
                else if (a == 7'h40) r = 7'h27;
                else                 r = a - 7'd1;
            end
        end else begin
            if (inc) begin
                if (a == 7'h4F)      r = 7'h00;
                else                 r = a + 7'd1;
            end else begin
                if (a == 7'h00)      r = 7'h4F;
                else                 r = a - 7'd1;
            end
        end
        return r;
    endfunction

    // Strobe detection, byte assembly and busy duration selection.
    always_comb begin
        strobe_s    = e_r & ~bus.e;
        accept_s    = strobe_s & ~busy_r & (~four_bit_r | phase_lo_r);
        full_byte_s = four_bit_r ? {hi_r, bus.db} : {bus.db, 4'h0};
        busy_load_s = 16'(CMD_BUSY_CYCLES);
        if (!bus.rs) begin
            if (full_byte_s == 8'h01) begin
                busy_load_s = 16'(CLR_CYCLES);
            end else if (full_byte_s[7:1] == 7'h01) begin
                busy_load_s = 16'(CLEAR_BUSY_CYCLES);
            end else begin
                busy_load_s = 16'(CMD_BUSY_CYCLES);
            end
        end else begin
            busy_load_s = 16'(CMD_BUSY_CYCLES);
        end
    end

    // Reset gates the write so an in-flight Clear stops without touching the current address.
    always_comb begin
        ddram_we_s    = rst & (clr_active_r | (accept_s & bus.rs & ~cg_sel_r));
        ddram_waddr_s = clr_active_r ? clr_addr_r : ac_r;
        ddram_wdata_s = clr_active_r ? 8'h20 : full_byte_s;
    end

    // Control state: nibble phase, busy timer, mode bits, address counters and Clear engine.
    always_ff @(posedge clk) begin
        if (!rst) begin
            e_r          <= 1'b0;
            phase_lo_r   <= 1'b0;
            hi_r         <= 4'h0;
            busy_r       <= 1'b0;
            busy_cnt_r   <= 16'd0;
            byte_valid_r <= 1'b0;
            byte_rs_r    <= 1'b0;
            byte_data_r  <= 8'h00;
            violation_r  <= 1'b0;
            ac_r         <= 7'h00;
            cg_sel_r     <= 1'b0;
            cg_addr_r    <= 6'h00;
            four_bit_r   <= 1'b0;
            two_line_r   <= 1'b0;
            disp_on_r    <= 1'b0;
            cursor_on_r  <= 1'b0;
            blink_r      <= 1'b0;
            entry_id_r   <= 1'b1;
            entry_s_r    <= 1'b0;
            clr_active_r <= 1'b0;
            clr_addr_r   <= 7'h00;
        end else begin
            e_r          <= bus.e;
            byte_valid_r <= 1'b0;
            violation_r  <= 1'b0;
            if (clr_active_r) begin
                clr_addr_r <= clr_addr_r + 7'd1;
                if (clr_addr_r == 7'h7F) begin
                    clr_active_r <= 1'b0;
                end
            end
            if (busy_r) begin
                busy_cnt_r <= busy_cnt_r - 16'd1;
                if (busy_cnt_r <= 16'd1) begin
                    busy_r <= 1'b0;
                end
            end
            if (strobe_s) begin
                if (busy_r) begin
                    violation_r <= 1'b1;
                end else if (four_bit_r && !phase_lo_r) begin
                    hi_r       <= bus.db;
                    phase_lo_r <= 1'b1;
                end else begin
                    phase_lo_r   <= 1'b0;
                    byte_valid_r <= 1'b1;
                    byte_rs_r    <= bus.rs;
                    byte_data_r  <= full_byte_s;
                    busy_r       <= 1'b1;
                    busy_cnt_r   <= busy_load_s;
                    if (bus.rs) begin
                        if (!cg_sel_r) begin
                            ac_r <= step_addr(ac_r, entry_id_r, two_line_r);
                        end else begin
                            cg_addr_r <= entry_id_r ? (cg_addr_r + 6'd1) : (cg_addr_r - 6'd1);
                        end
                    end else begin
                        casez (full_byte_s)
                            8'b1???????: begin
                                cg_sel_r <= 1'b0;
                                ac_r     <= full_byte_s[6:0];
                            end
                            8'b01??????: begin
                                cg_sel_r  <= 1'b1;
                                cg_addr_r <= full_byte_s[5:0];
                            end
                            8'b001?????: begin
                                four_bit_r <= ~full_byte_s[4];
                                two_line_r <= full_byte_s[3];
                            end
                            8'b0001????: begin
                                if (!full_byte_s[3]) begin
                                    ac_r <= step_addr(ac_r, full_byte_s[2], two_line_r);
                                end
                            end
                            8'b00001???: begin
                                disp_on_r   <= full_byte_s[2];
                                cursor_on_r <= full_byte_s[1];
                                blink_r     <= full_byte_s[0];
                            end
                            8'b000001??: begin
                                entry_id_r <= full_byte_s[1];
                                entry_s_r  <= full_byte_s[0];
                            end
                            8'b0000001?: begin
                                ac_r <= 7'h00;
                            end
                            8'b00000001: begin
                                ac_r         <= 7'h00;
                                entry_id_r   <= 1'b1;
                                clr_active_r <= 1'b1;
                                clr_addr_r   <= 7'h00;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
        end
    end

    // DDRAM storage and inspection read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ddram_we_s) begin
            ddram[ddram_waddr_s] <= ddram_wdata_s;
        end
        rdata_r <= ddram[raddr];
    end

`ifdef HD44780_SINK_CGRAM_EN
    logic [7:0] cgram [0:63];
    logic [7:0] cg_rdata_r;
    logic       cg_we_s;

    assign cg_we_s  = rst & accept_s & bus.rs & cg_sel_r;
    assign cg_rdata = cg_rdata_r;

    // CGRAM storage and inspection read port.
    always_ff @(posedge clk) begin
        if (cg_we_s) begin
            cgram[cg_addr_r] <= full_byte_s;
        end
        cg_rdata_r <= cgram[cg_raddr];
    end
`endif

    assign bus.busy       = busy_r;
    assign bus.byte_valid = byte_valid_r;
    assign bus.byte_rs    = byte_rs_r;
    assign bus.byte_data  = byte_data_r;
    assign bus.violation  = violation_r;
    assign rdata          = rdata_r;
    assign ac             = ac_r;
    assign four_bit       = four_bit_r;
    assign two_line       = two_line_r;
    assign disp_on        = disp_on_r;
    assign cursor_on      = cursor_on_r;
    assign blink          = blink_r;
    assign entry_id       = entry_id_r;
    assign entry_s        = entry_s_r;

endmodule

// File: tb/tb_hd44780_sink.sv
// Directed self-checking bench for hd44780_sink with hand-computed expectations.
module tb_hd44780_sink;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] raddr = 7'h00;
    logic [7:0] rdata;
    logic [6:0] ac;
    logic       four_bit, two_line, disp_on, cursor_on, blink, entry_id, entry_s;
`ifdef HD44780_SINK_CGRAM_EN
    logic [5:0] cg_raddr = 6'h00;
    logic [7:0] cg_rdata;
`endif

    hd44780_sink_if bus ();

    hd44780_sink dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .raddr     (raddr),
        .rdata     (rdata),
        .ac        (ac),
        .four_bit  (four_bit),
        .two_line  (two_line),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink     (blink),
        .entry_id  (entry_id),
        .entry_s   (entry_s)
`ifdef HD44780_SINK_CGRAM_EN
        ,
        .cg_raddr  (cg_raddr),
        .cg_rdata  (cg_rdata)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns on the falling clock edge right after the strobe has been processed.
    task automatic strobe(input logic rs_v, input logic [3:0] d);
        @(negedge clk);
        bus.e  = 1'b1;
        bus.rs = rs_v;
        bus.db = d;
        @(negedge clk);
        bus.e  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic rs_v, input logic [7:0] b);
        int n;
        int exp_n;
        strobe(rs_v, b[7:4]);
        check_val("hi_nibble_no_valid", {31'd0, bus.byte_valid}, 32'd0);
        strobe(rs_v, b[3:0]);
        check_val("byte_valid", {31'd0, bus.byte_valid}, 32'd1);
        check_val("byte_data", {24'd0, bus.byte_data}, {24'd0, b});
        check_val("byte_rs", {31'd0, bus.byte_rs}, {31'd0, rs_v});
        exp_n = 20;
        if (!rs_v && (b == 8'h01 || b == 8'h02 || b == 8'h03)) exp_n = 410;
        wait_ready(n);
        check_val("busy_cycles", n, exp_n);
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk);
        raddr = a;
        @(negedge clk);
        d = rdata;
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] d;
        bus.e  = 1'b0;
        bus.rs = 1'b0;
        bus.db = 4'h0;
        rst    = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_four_bit", {31'd0, four_bit}, 32'd0);
        check_val("rst_two_line", {31'd0, two_line}, 32'd0);
        check_val("rst_disp_on", {31'd0, disp_on}, 32'd0);
        check_val("rst_entry_id", {31'd0, entry_id}, 32'd1);
        check_val("rst_entry_s", {31'd0, entry_s}, 32'd0);
        check_val("rst_ac", {25'd0, ac}, 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
        check_val("rst_violation", {31'd0, bus.violation}, 32'd0);
        rst = 1'b1;

        // 8-bit function set selecting 4-bit mode
        strobe(1'b0, 4'h2);
        check_val("fs8_valid", {31'd0, bus.byte_valid}, 32'd1);
        check_val("fs8_data", {24'd0, bus.byte_data}, 32'h20);
        check_val("fs8_four_bit", {31'd0, four_bit}, 32'd1);
        check_val("fs8_busy", {31'd0, bus.busy}, 32'd1);
        wait_ready(n);
        check_val("fs8_busy_cycles", n, 32'd20);

        send(1'b0, 8'h28);
        check_val("two_line_set", {31'd0, two_line}, 32'd1);
        send(1'b0, 8'h0C);
        check_val("disp_on_set", {31'd0, disp_on}, 32'd1);
        check_val("cursor_off", {31'd0, cursor_on}, 32'd0);
        check_val("blink_off", {31'd0, blink}, 32'd0);

        send(1'b1, 8'h55);
        check_val("ac_after_data", {25'd0, ac}, 32'd1);
        rd(7'h00, d);
        check_val("ddram0_55", {24'd0, d}, 32'h55);

        send(1'b0, 8'h01);
        check_val("clear_ac", {25'd0, ac}, 32'd0);
        check_val("clear_entry_id", {31'd0, entry_id}, 32'd1);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            rd(7'(i), d);
            if (d !== 8'h20) bad++;
        end
        check_val("clear_fill_bad", bad, 32'd0);

        // Two-line wrap from the end of line 1 to line 2
        send(1'b0, 8'hA7);
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        rd(7'h27, d);
        check_val("ddram27_A", {24'd0, d}, 32'h41);
        rd(7'h40, d);
        check_val("ddram40_B", {24'd0, d}, 32'h42);
        check_val("ac_41", {25'd0, ac}, 32'h41);

        send(1'b0, 8'h04);
        check_val("entry_id_dec", {31'd0, entry_id}, 32'd0);
        send(1'b0, 8'hC0);
        send(1'b1, 8'h33);
        check_val("dec_40_to_27", {25'd0, ac}, 32'h27);
        send(1'b0, 8'h80);
        send(1'b0, 8'h10);
        check_val("shift_00_to_67", {25'd0, ac}, 32'h67);
        send(1'b0, 8'h06);
        send(1'b0, 8'hE7);
        send(1'b0, 8'h14);
        check_val("shift_67_to_00", {25'd0, ac}, 32'h00);
        send(1'b0, 8'hD0);
        send(1'b0, 8'h14);
        check_val("unmapped_inc", {25'd0, ac}, 32'h51);
        send(1'b0, 8'h1C);
        check_val("display_shift_no_ac", {25'd0, ac}, 32'h51);

        send(1'b0, 8'h40);
        send(1'b1, 8'hEE);
        check_val("cg_data_ac_kept", {25'd0, ac}, 32'h51);
        rd(7'h51, d);
        check_val("cg_data_no_ddram", {24'd0, d}, 32'h20);
        send(1'b0, 8'h80);
        send(1'b0, 8'hD0);
        send(1'b0, 8'h02);
        check_val("home_ac", {25'd0, ac}, 32'h00);

        // Strobe five cycles into a busy period
        strobe(1'b0, 4'h0);
        strobe(1'b0, 4'hF);
        check_val("dc_valid", {31'd0, bus.byte_valid}, 32'd1);
        repeat (3) @(negedge clk);
        strobe(1'b0, 4'h5);
        check_val("viol_pulse", {31'd0, bus.violation}, 32'd1);
        check_val("viol_no_valid", {31'd0, bus.byte_valid}, 32'd0);
        @(negedge clk);
        check_val("viol_one_cycle", {31'd0, bus.violation}, 32'd0);
        wait_ready(n);
        check_val("viol_busy_rest", n, 32'd13);
        check_val("dc_blink", {31'd0, blink}, 32'd1);
        send(1'b0, 8'h08);
        check_val("phase_kept_disp_off", {31'd0, disp_on}, 32'd0);

        send(1'b0, 8'h20);
        check_val("one_line", {31'd0, two_line}, 32'd0);
        send(1'b0, 8'hCF);
        send(1'b0, 8'h14);
        check_val("one_line_4f_to_00", {25'd0, ac}, 32'h00);
        send(1'b0, 8'h10);
        check_val("one_line_00_to_4f", {25'd0, ac}, 32'h4F);
        send(1'b0, 8'h28);

        send(1'b0, 8'hFF);
        send(1'b1, 8'h99);
        send(1'b0, 8'hB0);
        send(1'b1, 8'h77);
        send(1'b0, 8'hAF);
        send(1'b1, 8'h66);
        strobe(1'b0, 4'h0);
        strobe(1'b0, 4'h1);
        check_val("clr2_valid", {31'd0, bus.byte_valid}, 32'd1);
        repeat (48) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_val("abort_four_bit", {31'd0, four_bit}, 32'd0);
        rst = 1'b1;
        rd(7'h2F, d);
        check_val("abort_2f_cleared", {24'd0, d}, 32'h20);
        rd(7'h30, d);
        check_val("abort_30_kept", {24'd0, d}, 32'h77);
        rd(7'h7F, d);
        check_val("abort_7f_kept", {24'd0, d}, 32'h99);
        check_val("abort_ac", {25'd0, ac}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
